// File: rtl/seq_calculator_pkg.sv
// Shared types for the sequential calculator: opcodes and controller states.
package seq_calculator_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/seq_calculator_muldiv.sv
// Iterative W-cycle shift-add multiplier / restoring divider sharing one
// accumulator and shift register. Exposes next-state values so the final
// iteration can be captured on the same edge it completes.
module seq_calculator_muldiv #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         last,
  output logic [W-1:0] hi_nxt,
  output logic [W-1:0] lo_nxt
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sh_q, sh_d;
  logic [W-1:0]  m_q, m_d;
  logic          div_q, div_d;
  logic          act_q, act_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W:0]    sum;
  logic [W:0]    shifted;
  logic [W-1:0]  diff;

  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, (sh_q[0] ? m_q : {W{1'b0}})};
    shifted = {acc_q, sh_q[W-1]};
    // remainder after a successful subtract is < divisor, so W bits suffice
    diff    = shifted[W-1:0] - m_q;

    if (div_q) begin
      if (shifted >= {1'b0, m_q}) begin
        hi_nxt = diff;
        lo_nxt = {sh_q[W-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[W-1:0];
        lo_nxt = {sh_q[W-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[W:1];
      lo_nxt = {sum[0], sh_q[W-1:1]};
    end

    last = act_q && (cnt_q == CW'(W - 1));

    acc_d = acc_q;
    sh_d  = sh_q;
    m_d   = m_q;
    div_d = div_q;
    act_d = act_q;
    cnt_d = cnt_q;

    if (start) begin
      acc_d = '0;
      sh_d  = a;
      m_d   = b;
      div_d = is_div;
      act_d = 1'b1;
      cnt_d = '0;
    end else if (act_q) begin
      acc_d = hi_nxt;
      sh_d  = lo_nxt;
      cnt_d = cnt_q + CW'(1);
      if (last) act_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      sh_q  <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
      act_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      m_q   <= m_d;
      div_q <= div_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_calculator.sv
// Sequential calculator: single-cycle add/sub, W-cycle iterative mul/div,
// with a one-cycle done pulse and results held until the next completion.
module seq_calculator
  import seq_calculator_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic [W-1:0] ext,
  output logic         carry,
  output logic         err
);

  state_e       state_q, state_d;
  op_e          op_q, op_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [W-1:0] result_q, result_d;
  logic [W-1:0] ext_q, ext_d;
  logic         carry_q, carry_d;
  logic         err_q, err_d;

  op_e          op_in;
  logic [W:0]   add_w;
  logic [W:0]   sub_w;
  logic         md_start;
  logic         md_last;
  logic [W-1:0] md_hi;
  logic [W-1:0] md_lo;

  always_comb begin
    op_in = op_e'(op);
    add_w = {1'b0, a} + {1'b0, b};
    sub_w = {1'b0, a} - {1'b0, b};

    state_d  = state_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    ext_d    = ext_q;
    carry_d  = carry_q;
    err_d    = err_q;
    md_start = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (st) begin
          op_d = op_in;
          case (op_in)
            OP_ADD, OP_SUB: begin
              {carry_d, result_d} = (op_in == OP_ADD) ? add_w : sub_w;
              ext_d   = '0;
              err_d   = 1'b0;
              done_d  = 1'b1;
              state_d = DONE;
            end
            OP_DIV: begin
              if (b == '0) begin
                result_d = '1;
                ext_d    = a;
                carry_d  = 1'b0;
                err_d    = 1'b1;
                done_d   = 1'b1;
                state_d  = DONE;
              end else begin
                md_start = 1'b1;
                busy_d   = 1'b1;
                state_d  = CALC;
              end
            end
            default: begin
              md_start = 1'b1;
              busy_d   = 1'b1;
              state_d  = CALC;
            end
          endcase
        end
      end
      CALC: begin
        if (md_last) begin
          result_d = md_lo;
          ext_d    = md_hi;
          carry_d  = (op_q == OP_MUL) ? (|md_hi) : 1'b0;
          err_d    = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ext_q    <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ext_q    <= ext_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  seq_calculator_muldiv #(
    .W(W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst),
    .start  (md_start),
    .is_div (op_in == OP_DIV),
    .a      (a),
    .b      (b),
    .last   (md_last),
    .hi_nxt (md_hi),
    .lo_nxt (md_lo)
  );

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ext    = ext_q;
  assign carry  = carry_q;
  assign err    = err_q;

endmodule

// File: tb/tb_seq_calculator.sv
// Directed vector bench for seq_calculator (W=8): table of operations with
// hand-computed results plus sequences for ignore, reset and back-to-back cases.
module tb_seq_calculator;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         st;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] ext;
  logic         carry;
  logic         err;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  seq_calculator #(
    .W(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ext    (ext),
    .carry  (carry),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    logic [7:0]  ext;
    logic        carry;
    logic        err;
    int unsigned lat;
    int unsigned busy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called #1 after a posedge; returns #1 after the edge where done is seen.
  task automatic run_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int unsigned lat, output int unsigned bcnt);
    lat  = 0;
    bcnt = 0;
    st = 1'b1; op = o; a = x; b = y;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        st = 1'b0; op = ~o; a = ~x; b = ~y;
      end
      lat++;
      if (done) break;
      if (busy) bcnt++;
    end
    if (!done) lat = 999;
  endtask

  int unsigned lat, bc, pulses;
  logic [7:0] held;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b00, 8'd200, 8'd100, 8'd44,   8'd0,    1'b1, 1'b0, 1, 0};
    vecs[1]  = '{2'b01, 8'd5,   8'd9,   8'd252,  8'd0,    1'b1, 1'b0, 1, 0};
    vecs[2]  = '{2'b00, 8'd127, 8'd1,   8'd128,  8'd0,    1'b0, 1'b0, 1, 0};
    vecs[3]  = '{2'b01, 8'd9,   8'd5,   8'd4,    8'd0,    1'b0, 1'b0, 1, 0};
    vecs[4]  = '{2'b10, 8'd200, 8'd200, 8'h40,   8'h9C,   1'b1, 1'b0, 9, 8};
    vecs[5]  = '{2'b10, 8'd15,  8'd17,  8'd255,  8'd0,    1'b0, 1'b0, 9, 8};
    vecs[6]  = '{2'b10, 8'd255, 8'd255, 8'h01,   8'hFE,   1'b1, 1'b0, 9, 8};
    vecs[7]  = '{2'b10, 8'd0,   8'd123, 8'd0,    8'd0,    1'b0, 1'b0, 9, 8};
    vecs[8]  = '{2'b11, 8'd100, 8'd7,   8'd14,   8'd2,    1'b0, 1'b0, 9, 8};
    vecs[9]  = '{2'b11, 8'd37,  8'd0,   8'hFF,   8'd37,   1'b0, 1'b1, 1, 0};
    vecs[10] = '{2'b11, 8'd255, 8'd1,   8'd255,  8'd0,    1'b0, 1'b0, 9, 8};
    vecs[11] = '{2'b11, 8'd5,   8'd9,   8'd0,    8'd5,    1'b0, 1'b0, 9, 8};

    rst = 1'b0; st = 1'b0; op = 2'b00; a = '0; b = '0;
    #12;
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_ext",    32'(ext),    32'd0);
    check("reset_carry",  32'(carry),  32'd0);
    check("reset_err",    32'(err),    32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      check($sformatf("v%0d_ext", i),    32'(ext),    32'(vecs[i].ext));
      check($sformatf("v%0d_carry", i),  32'(carry),  32'(vecs[i].carry));
      check($sformatf("v%0d_err", i),    32'(err),    32'(vecs[i].err));
      check($sformatf("v%0d_latency", i), lat,        vecs[i].lat);
      check($sformatf("v%0d_busy_cycles", i), bc,     vecs[i].busy);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_single", i), 32'(done), 32'd0);
    end

    // back-to-back: add requested during the DONE cycle of a mul
    run_op(2'b10, 8'd200, 8'd200, lat, bc);
    check("b2b_mul_result", 32'(result), 32'h40);
    check("b2b_mul_latency", lat, 32'd9);
    st = 1'b1; op = 2'b00; a = 8'd3; b = 8'd4;
    @(posedge clk); #1;
    st = 1'b0;
    check("b2b_add_done",   32'(done),   32'd1);
    check("b2b_add_result", 32'(result), 32'd7);
    check("b2b_add_ext",    32'(ext),    32'd0);
    @(posedge clk); #1;
    check("b2b_done_drop",  32'(done),   32'd0);

    // st with another op while a mul is running must be ignored
    pulses = 0;
    st = 1'b1; op = 2'b10; a = 8'd200; b = 8'd200;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (i == 0) st = 1'b0;
      if (i == 2) begin st = 1'b1; op = 2'b00; a = 8'd1; b = 8'd1; end
      if (i == 5) st = 1'b0;
      if (done) begin
        pulses++;
        check("ign_result", 32'(result), 32'h40);
        check("ign_ext",    32'(ext),    32'h9C);
        check("ign_done_time", 32'(i), 32'd8);
      end
    end
    check("ign_pulses", pulses, 32'd1);

    // result holds between completions while inputs wander
    held = result;
    for (int i = 0; i < 3; i++) begin
      a = 8'(i * 37); b = 8'(i + 5); op = 2'(i);
      @(posedge clk); #1;
    end
    check("hold_result", 32'(result), 32'h40);
    check("hold_ext",    32'(ext),    32'h9C);
    check("hold_carry",  32'(carry),  32'd1);

    // reset during cycle 4 of a div
    st = 1'b1; op = 2'b11; a = 8'd100; b = 8'd7;
    @(posedge clk); #1;
    st = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    check("prerst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_ext",    32'(ext),    32'd0);
    check("rst_carry",  32'(carry),  32'd0);
    check("rst_err",    32'(err),    32'd0);
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("rst_no_done", pulses, 32'd0);
    run_op(2'b00, 8'd1, 8'd1, lat, bc);
    check("post_rst_result",  32'(result), 32'd2);
    check("post_rst_latency", lat,         32'd1);
    check("post_rst_carry",   32'(carry),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
